// File: rtl/arbitro_pkg.sv
// Shared types and default sizing for the round-robin compute-unit scheduler.
package arbitro_pkg;

    localparam int unsigned N_REQ_DEF   = 4;
    localparam int unsigned W_N_DEF     = 3;
    localparam int unsigned W_OUT_DEF   = 13;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        LIBRE,
        LANZA,
        BAJA,
        ESPERA,
        ENTREGA
    } estado_t;

endpackage

// File: rtl/arbitro_sistema_if.sv
// Client-side request/acknowledge bundle between the requesters and the scheduler.
interface arbitro_sistema_if
    import arbitro_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned W_N   = W_N_DEF,
    parameter int unsigned W_OUT = W_OUT_DEF
);

    localparam int unsigned W_ID = $clog2(N_REQ);

    logic [N_REQ-1:0]     req;
    logic [N_REQ*W_N-1:0] n_req;
    logic [N_REQ-1:0]     ack;
    logic [W_OUT-1:0]     resultado;
    logic                 error;
    logic                 ocupado;
    logic [W_ID-1:0]      id_actual;

    modport master (
        output req,
        output n_req,
        input  ack,
        input  resultado,
        input  error,
        input  ocupado,
        input  id_actual
    );

    modport slave (
        input  req,
        input  n_req,
        output ack,
        output resultado,
        output error,
        output ocupado,
        output id_actual
    );

endinterface

// File: rtl/arbitro_sistema_selector_rr.sv
// Combinational round-robin priority encoder: first set request at or after the pointer.
module selector_rr
    import arbitro_pkg::*;
#(
    parameter int unsigned  N_REQ = N_REQ_DEF,
    localparam int unsigned W_ID  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [W_ID-1:0]  puntero,
    output logic             valid,
    output logic [W_ID-1:0]  winner
);

    int unsigned idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        // Scan from the farthest offset down so the closest request to the pointer wins last.
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            idx = (32'(puntero) + 32'(i)) % N_REQ;
            if (req[idx]) begin
                valid  = 1'b1;
                winner = W_ID'(idx);
            end
        end
    end

endmodule

// File: rtl/arbitro_sistema.sv
// Shares one iterative compute unit among N_REQ clients, round-robin, with a fin timeout.
module arbitro_sistema
    import arbitro_pkg::*;
#(
    parameter int unsigned  N_REQ   = N_REQ_DEF,
    parameter int unsigned  W_N     = W_N_DEF,
    parameter int unsigned  W_OUT   = W_OUT_DEF,
    parameter int unsigned  TIMEOUT = TIMEOUT_DEF,
    localparam int unsigned W_ID    = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    arbitro_sistema_if.slave        bus,
    output logic                    inicio,
    output logic [W_N-1:0]          n_sis,
    input  logic [W_OUT-1:0]        salida,
    input  logic                    fin
);

    localparam int unsigned W_CNT = $clog2(TIMEOUT + 1);

    estado_t            estado_q;
    logic [W_ID-1:0]    puntero_q;
    logic [W_ID-1:0]    id_q;
    logic [W_CNT-1:0]   cuenta_q;
    logic [N_REQ-1:0]   ack_q;
    logic [W_OUT-1:0]   resultado_q;
    logic               error_q;
    logic               ocupado_q;
    logic               inicio_q;
    logic [W_N-1:0]     n_sis_q;

    logic               sel_valid;
    logic [W_ID-1:0]    sel_id;
    logic [W_ID-1:0]    puntero_sig;
    logic [W_CNT-1:0]   cuenta_sig;
    logic               agotado;
    logic [N_REQ-1:0]   mascara_id;
    logic [W_N-1:0]     n_elegido;

    selector_rr #(
        .N_REQ (N_REQ)
    ) u_selector (
        .req     (bus.req),
        .puntero (puntero_q),
        .valid   (sel_valid),
        .winner  (sel_id)
    );

    assign puntero_sig = (sel_id == W_ID'(N_REQ - 1)) ? '0 : sel_id + 1'b1;
    assign cuenta_sig  = cuenta_q + 1'b1;
    assign agotado     = (cuenta_sig == W_CNT'(TIMEOUT));
    assign mascara_id  = {{(N_REQ - 1){1'b0}}, 1'b1} << id_q;
    assign n_elegido   = bus.n_req[sel_id * W_N +: W_N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q    <= LIBRE;
            puntero_q   <= '0;
            id_q        <= '0;
            cuenta_q    <= '0;
            ack_q       <= '0;
            resultado_q <= '0;
            error_q     <= 1'b0;
            ocupado_q   <= 1'b0;
            inicio_q    <= 1'b0;
            n_sis_q     <= '0;
        end else begin
            inicio_q <= 1'b0;
            ack_q    <= '0;
            unique case (estado_q)
                LIBRE: begin
                    if (sel_valid) begin
                        id_q      <= sel_id;
                        n_sis_q   <= n_elegido;
                        puntero_q <= puntero_sig;
                        inicio_q  <= 1'b1;
                        ocupado_q <= 1'b1;
                        estado_q  <= LANZA;
                    end
                end
                LANZA: begin
                    cuenta_q <= '0;
                    estado_q <= BAJA;
                end
                BAJA: begin
                    // A fin still high here belongs to the previous job and must be ignored.
                    cuenta_q <= cuenta_sig;
                    if (agotado) begin
                        resultado_q <= '0;
                        error_q     <= 1'b1;
                        ack_q       <= bus.req & mascara_id;
                        estado_q    <= ENTREGA;
                    end else if (!fin) begin
                        estado_q <= ESPERA;
                    end
                end
                ESPERA: begin
                    cuenta_q <= cuenta_sig;
                    if (fin) begin
                        resultado_q <= salida;
                        error_q     <= 1'b0;
                        ack_q       <= bus.req & mascara_id;
                        estado_q    <= ENTREGA;
                    end else if (agotado) begin
                        resultado_q <= '0;
                        error_q     <= 1'b1;
                        ack_q       <= bus.req & mascara_id;
                        estado_q    <= ENTREGA;
                    end
                end
                ENTREGA: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= LIBRE;
                end
                default: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= LIBRE;
                end
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.resultado = resultado_q;
    assign bus.error     = error_q;
    assign bus.ocupado   = ocupado_q;
    assign bus.id_actual = id_q;
    assign inicio        = inicio_q;
    assign n_sis         = n_sis_q;

endmodule

// File: tb/tb_arbitro_sistema.sv
// Directed and randomized checks of arbitro_sistema against a factorial unit model.
module tb_arbitro_sistema;
    import arbitro_pkg::*;

    localparam int N   = 4;
    localparam int WN  = 3;
    localparam int WO  = 13;
    localparam int TO  = 255;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    arbitro_sistema_if #(.N_REQ(N), .W_N(WN), .W_OUT(WO)) bus ();

    logic          inicio;
    logic [WN-1:0] n_sis;
    logic [WO-1:0] salida;
    logic          fin;

    arbitro_sistema #(
        .N_REQ   (N),
        .W_N     (WN),
        .W_OUT   (WO),
        .TIMEOUT (TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .inicio (inicio),
        .n_sis  (n_sis),
        .salida (salida),
        .fin    (fin)
    );

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;
    int hold   = 0;
    bit mute   = 1'b0;
    logic [WN-1:0] n_val [N];

    function automatic logic [WO-1:0] fact(input int n);
        int r;
        r = 1;
        for (int i = 2; i <= n; i++) r = r * i;
        return WO'(r);
    endfunction

    function automatic int pick(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            if (m[(ptr_m + i) % N]) return (ptr_m + i) % N;
        end
        return -1;
    endfunction

    // Compute-unit model: n! after LAT cycles; fin stays high until `hold` cycles past inicio.
    int            cnt_u;
    int            drop_u;
    logic          busy_u;
    logic [WN-1:0] nq_u;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fin    <= 1'b0;
            salida <= '0;
            cnt_u  <= 0;
            drop_u <= 0;
            busy_u <= 1'b0;
            nq_u   <= '0;
        end else if (inicio) begin
            cnt_u  <= LAT + hold;
            drop_u <= hold;
            nq_u   <= n_sis;
            busy_u <= 1'b1;
            if (hold == 0) fin <= 1'b0;
        end else begin
            if (drop_u != 0) begin
                drop_u <= drop_u - 1;
                if (drop_u == 1) fin <= 1'b0;
            end
            if (busy_u && !mute) begin
                if (cnt_u == 1) begin
                    fin    <= 1'b1;
                    salida <= fact(int'(nq_u));
                    busy_u <= 1'b0;
                end else begin
                    cnt_u <= cnt_u - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input int nv);
        n_val[id] = WN'(nv);
        bus.n_req[id*WN +: WN] = WN'(nv);
        bus.req[id] = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, 32'(bus.ack), 0);
        chk({tag, "_resultado"}, 32'(bus.resultado), 0);
        chk({tag, "_error"}, 32'(bus.error), 0);
        chk({tag, "_inicio"}, 32'(inicio), 0);
        chk({tag, "_n_sis"}, 32'(n_sis), 0);
        chk({tag, "_id_actual"}, 32'(bus.id_actual), 0);
        chk({tag, "_ocupado"}, 32'(bus.ocupado), 0);
    endtask

    // One full job for client id; lat counts cycles from the inicio cycle to the ack cycle.
    task automatic serve(input int id, input logic [WO-1:0] res, input logic err, input int lat);
        int k;
        k = 0;
        while (inicio !== 1'b1 && k < TO + 50) begin
            @(negedge clk);
            k++;
        end
        chk("inicio_seen", 32'(inicio), 1);
        chk("id_actual", 32'(bus.id_actual), 32'(id));
        chk("n_sis", 32'(n_sis), 32'(n_val[id]));
        chk("ocupado_busy", 32'(bus.ocupado), 1);
        bus.n_req[id*WN +: WN] = ~n_val[id];
        @(negedge clk);
        chk("inicio_pulse", 32'(inicio), 0);
        k = 1;
        while (bus.ack === '0 && k < TO + 50) begin
            @(negedge clk);
            k++;
        end
        chk("ack_client", 32'(bus.ack), 32'(1) << id);
        chk("resultado", 32'(bus.resultado), 32'(res));
        chk("error", 32'(bus.error), 32'(err));
        chk("latency", 32'(k), 32'(lat));
        chk("n_sis_frozen", 32'(n_sis), 32'(n_val[id]));
        bus.req[id] = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", 32'(bus.ack), 0);
        chk("ocupado_idle", 32'(bus.ocupado), 0);
        ptr_m = (id + 1) % N;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int acks;
        logic [N-1:0] m;
        int w;
        bus.req   = '0;
        bus.n_req = '0;
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // All four at once: strict order from pointer 0.
        set_req(0, 0); set_req(1, 3); set_req(2, 6); set_req(3, 7);
        serve(0, 13'd1, 1'b0, LAT + 2);
        serve(1, 13'd6, 1'b0, LAT + 2);
        serve(2, 13'd720, 1'b0, LAT + 2);
        serve(3, 13'd5040, 1'b0, LAT + 2);
        set_req(3, 2); set_req(0, 4);
        serve(0, 13'd24, 1'b0, LAT + 2);
        serve(3, 13'd2, 1'b0, LAT + 2);

        set_req(2, 5);
        serve(2, 13'd120, 1'b0, LAT + 2);

        // Fairness: client 1 re-requests immediately, client 3 must still get in.
        set_req(1, 2);
        @(negedge clk);
        set_req(3, 1);
        serve(1, 13'd2, 1'b0, LAT + 2);
        set_req(1, 2);
        serve(3, 13'd1, 1'b0, LAT + 2);
        serve(1, 13'd2, 1'b0, LAT + 2);

        mute = 1'b1;
        set_req(0, 3);
        serve(0, 13'd0, 1'b1, TO + 1);
        mute = 1'b0;
        set_req(0, 3);
        serve(0, 13'd6, 1'b0, LAT + 2);

        // Stale fin from the previous job lingers into BAJA.
        hold = 3;
        set_req(2, 4);
        serve(2, 13'd24, 1'b0, LAT + 5);

        set_req(1, 5);
        @(negedge clk);
        chk("wd_inicio", 32'(inicio), 1);
        chk("wd_id", 32'(bus.id_actual), 1);
        set_req(2, 3);
        repeat (6) @(negedge clk);
        bus.req[1] = 1'b0;
        acks = 0;
        k = 0;
        while (bus.ocupado === 1'b1 && k < 50) begin
            if (bus.ack !== '0) acks++;
            @(negedge clk);
            k++;
        end
        chk("wd_no_ack", 32'(acks), 0);
        chk("wd_idle", 32'(bus.ocupado), 0);
        chk("wd_resultado", 32'(bus.resultado), 32'(fact(5)));
        ptr_m = 2;
        serve(2, 13'd6, 1'b0, LAT + 5);
        hold = 0;

        // Reset in ESPERA with clients 0 and 2 waiting behind client 1.
        set_req(1, 6);
        @(negedge clk);
        set_req(0, 2); set_req(2, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        bus.req[1] = 1'b0;
        rst = 1'b0;
        ptr_m = 0;
        serve(0, 13'd2, 1'b0, LAT + 2);
        serve(2, 13'd1, 1'b0, LAT + 2);

        for (int r = 0; r < 10; r++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            hold = int'($urandom_range(0, 2));
            for (int i = 0; i < N; i++) begin
                if (m[i]) set_req(i, int'($urandom_range(0, 7)));
            end
            while (m != '0) begin
                w = pick(m);
                serve(w, fact(int'(n_val[w])), 1'b0, LAT + hold + 2);
                m[w] = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
